// File: rtl/pixel_write_frontend.sv
// rtl/pixel_write_frontend.sv - host pixel capture, display windowing and SRAM write queue
// Optional build macro: PAGE_FLIP_EN (double-buffered writes, page flips on each Vsync fall).
module pixel_write_frontend #(
    parameter int DISP_WIDTH  = 480,
    parameter int DISP_HEIGHT = 272,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        iCLOCKA,
    input  logic        iRESET,
    input  logic [15:0] iHostData,
    input  logic        iHostWClk,
    input  logic        iHostHsync,
    input  logic        iHostVsync,
    input  logic        iClearErr,
    output logic        oWrValid,
    input  logic        iWrReady,
    output logic [17:0] oWrAddr,
    output logic [23:0] oWrData,
    output logic        oDispPage,
    output logic        oOverflow,
    output logic        oClip
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 34;
    localparam logic [8:0]  H_LIM = 9'(DISP_WIDTH);
    localparam logic [8:0]  V_LIM = 9'(DISP_HEIGHT);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    logic [15:0]   data_s1_q, data_s2_q;
    logic [2:0]    strb_s1_q, strb_s2_q, strb_prev_q;
    logic [2:0]    strb_fall;
    logic          pix_fall, hs_fall, vs_fall;

    logic [8:0]    h_q, h_d;
    logic [8:0]    v_q, v_d;
    logic [16:0]   pix_index;
    logic          in_range;
    logic          wr_page;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_idx_q, rd_idx_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          full, push, pop;
    logic          ovf_evt, clip_evt;
    logic          ovf_q, clip_q;
    logic [EW-1:0] head;

    // Bit order in the strobe vectors: {vsync, hsync, wclk}. Reset to 1 so a
    // release with idle-high strobes produces no spurious edge.
    always_ff @(posedge iCLOCKA or negedge iRESET) begin
        if (!iRESET) begin
            data_s1_q   <= '1;
            data_s2_q   <= '1;
            strb_s1_q   <= '1;
            strb_s2_q   <= '1;
            strb_prev_q <= '1;
        end else begin
            data_s1_q   <= iHostData;
            data_s2_q   <= data_s1_q;
            strb_s1_q   <= {iHostVsync, iHostHsync, iHostWClk};
            strb_s2_q   <= strb_s1_q;
            strb_prev_q <= strb_s2_q;
        end
    end

    assign strb_fall = strb_prev_q & ~strb_s2_q;
    assign pix_fall  = strb_fall[0];
    assign hs_fall   = strb_fall[1];
    assign vs_fall   = strb_fall[2];

`ifdef PAGE_FLIP_EN
    logic wr_page_q;

    always_ff @(posedge iCLOCKA or negedge iRESET) begin
        if (!iRESET) begin
            wr_page_q <= 1'b0;
        end else if (vs_fall) begin
            wr_page_q <= ~wr_page_q;
        end
    end

    assign wr_page   = wr_page_q;
    assign oDispPage = ~wr_page_q;
`else
    assign wr_page   = 1'b0;
    assign oDispPage = 1'b0;
`endif

    assign in_range  = (h_q < H_LIM) && (v_q < V_LIM);
    assign pix_index = 17'(32'(v_q) * DISP_WIDTH + 32'(h_q));

    // A pixel always sees the pre-update pointers; sync strobes then apply,
    // with Vsync taking precedence over Hsync.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_fall && in_range) begin
            h_d = h_q + 9'd1;
        end
        if (vs_fall) begin
            h_d = 9'd0;
            v_d = 9'd0;
        end else if (hs_fall) begin
            h_d = 9'd0;
            v_d = (v_q < V_LIM) ? v_q + 9'd1 : v_q;
        end
    end

    always_ff @(posedge iCLOCKA or negedge iRESET) begin
        if (!iRESET) begin
            h_q <= 9'd0;
            v_q <= 9'd0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign full     = (cnt_q == FULL_CNT);
    assign pop      = oWrValid && iWrReady;
    assign push     = pix_fall && in_range && (!full || pop);
    assign ovf_evt  = pix_fall && in_range && full && !pop;
    assign clip_evt = pix_fall && !in_range;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge iCLOCKA or negedge iRESET) begin
        if (!iRESET) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                wr_idx_q <= wr_idx_q + 1'b1;
            end
            if (pop) begin
                rd_idx_q <= rd_idx_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy is governed solely by the pointers.
    always_ff @(posedge iCLOCKA) begin
        if (push) begin
            mem_q[wr_idx_q] <= {wr_page, pix_index, data_s2_q};
        end
    end

    assign head     = mem_q[rd_idx_q];
    assign oWrValid = (cnt_q != '0);
    assign oWrAddr  = head[33:16];
    assign oWrData  = {8'h00, head[15:0]};

    always_ff @(posedge iCLOCKA or negedge iRESET) begin
        if (!iRESET) begin
            ovf_q  <= 1'b0;
            clip_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_evt  || (ovf_q  && !iClearErr);
            clip_q <= clip_evt || (clip_q && !iClearErr);
        end
    end

    assign oOverflow = ovf_q;
    assign oClip     = clip_q;

endmodule

// File: tb/tb_pixel_write_frontend.sv
// tb/tb_pixel_write_frontend.sv - randomized self-checking bench for pixel_write_frontend
module tb_pixel_write_frontend;

    localparam int W = 480;
    localparam int H = 272;
    localparam int D = 8;

    logic        iCLOCKA = 1'b0;
    logic        iRESET = 1'b0;
    logic [15:0] iHostData = 16'h0000;
    logic        iHostWClk = 1'b1;
    logic        iHostHsync = 1'b1;
    logic        iHostVsync = 1'b1;
    logic        iClearErr = 1'b0;
    logic        oWrValid;
    logic        iWrReady = 1'b1;
    logic [17:0] oWrAddr;
    logic [23:0] oWrData;
    logic        oDispPage;
    logic        oOverflow;
    logic        oClip;

    always #5 iCLOCKA = ~iCLOCKA;

    pixel_write_frontend #(.DISP_WIDTH(W), .DISP_HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .iCLOCKA(iCLOCKA), .iRESET(iRESET), .iHostData(iHostData), .iHostWClk(iHostWClk),
        .iHostHsync(iHostHsync), .iHostVsync(iHostVsync), .iClearErr(iClearErr),
        .oWrValid(oWrValid), .iWrReady(iWrReady), .oWrAddr(oWrAddr), .oWrData(oWrData),
        .oDispPage(oDispPage), .oOverflow(oOverflow), .oClip(oClip)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: host-visible frame position, page and queued writes.
    int          mh = 0;
    int          mv = 0;
    bit          mpage = 1'b0;
    bit          movf = 1'b0;
    bit          mclip = 1'b0;
    int          occ = 0;
    logic [41:0] expq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_sync(input bit hs, input bit vs);
        if (vs) begin
            mh = 0;
            mv = 0;
`ifdef PAGE_FLIP_EN
            mpage = ~mpage;
`endif
        end else if (hs) begin
            mh = 0;
            if (mv < H) mv++;
        end
    endtask

    task automatic model_pixel(input logic [15:0] d, input bit hs, input bit vs);
        if (mh < W && mv < H) begin
            if (occ < D) begin
                expq.push_back({mpage, 17'(mv * W + mh), 8'h00, d});
                if (!iWrReady) occ++;
            end else begin
                movf = 1'b1;
            end
            mh++;
        end else begin
            mclip = 1'b1;
        end
        model_sync(hs, vs);
    endtask

    task automatic host_event(input logic [15:0] d, input bit px, input bit hs, input bit vs);
        @(posedge iCLOCKA); #1;
        iHostData = d;
        @(posedge iCLOCKA); #1;
        if (px) iHostWClk = 1'b0;
        if (hs) iHostHsync = 1'b0;
        if (vs) iHostVsync = 1'b0;
        if (px) model_pixel(d, hs, vs);
        else model_sync(hs, vs);
        repeat (3) @(posedge iCLOCKA);
        #1;
        iHostWClk = 1'b1;
        iHostHsync = 1'b1;
        iHostVsync = 1'b1;
        repeat (3) @(posedge iCLOCKA);
        #1;
    endtask

    task automatic set_ready(input bit r);
        @(posedge iCLOCKA); #1;
        iWrReady = r;
        if (r) begin
            repeat (D + 6) @(posedge iCLOCKA);
            #1;
            occ = 0;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && expq.size() != 0; i++) @(posedge iCLOCKA);
        #1;
        chk("drain_left", expq.size(), 0);
    endtask

    task automatic clear_errs();
        @(posedge iCLOCKA); #1;
        iClearErr = 1'b1;
        @(posedge iCLOCKA); #1;
        iClearErr = 1'b0;
        movf = 1'b0;
        mclip = 1'b0;
    endtask

    task automatic check_state(input string tag);
        bit exp_disp;
`ifdef PAGE_FLIP_EN
        exp_disp = ~mpage;
`else
        exp_disp = 1'b0;
`endif
        chk({tag, "_ovf"}, oOverflow, movf);
        chk({tag, "_clip"}, oClip, mclip);
        chk({tag, "_disp"}, oDispPage, exp_disp);
    endtask

    // Write scoreboard: every accepted handshake must match the model's next entry.
    always @(negedge iCLOCKA) begin
        if (iRESET && oWrValid && iWrReady) begin
            if (expq.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                logic [41:0] e;
                e = expq.pop_front();
                chk("wr_addr", oWrAddr, e[41:24]);
                chk("wr_data", oWrData, e[23:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge iCLOCKA);
        #1;
        chk("rst_valid", oWrValid, 0);
        check_state("rst");
        iRESET = 1'b1;
        repeat (3) @(posedge iCLOCKA);
        #1;
        chk("post_rst_valid", oWrValid, 0);

        // Two pixels at the frame origin.
        host_event(16'h1234, 1, 0, 0);
        host_event(16'hABCD, 1, 0, 0);
        wait_drain();

        // Three line strobes then a pixel at the start of line 3.
        host_event(16'h0000, 0, 0, 1);
        repeat (3) host_event(16'h0000, 0, 1, 0);
        host_event(16'hF800, 1, 0, 0);
        wait_drain();
        check_state("lines");

        // Pixel coinciding with Hsync and Vsync at H=5, V=2.
        host_event(16'h0000, 0, 0, 1);
        repeat (2) host_event(16'h0000, 0, 1, 0);
        for (int i = 0; i < 5; i++) host_event(16'(i + 16'h100), 1, 0, 0);
        host_event(16'h5A5A, 1, 1, 1);
        host_event(16'hC3C3, 1, 0, 0);
        wait_drain();
        check_state("same_cycle");

        // Stalled arbiter: the ninth in-range pixel is dropped.
        host_event(16'h0000, 0, 0, 1);
        set_ready(0);
        for (int i = 0; i < 9; i++) host_event(16'(16'h2000 + i), 1, 0, 0);
        chk("stall_valid", oWrValid, 1);
        check_state("overflow");
        set_ready(1);
        wait_drain();
        clear_errs();
        check_state("ovf_cleared");

        // A full line plus one: the extra pixel is clipped.
        host_event(16'h0000, 0, 0, 1);
        for (int i = 0; i < W + 1; i++) host_event(16'($urandom), 1, 0, 0);
        wait_drain();
        check_state("clip");
        clear_errs();
        check_state("clip_cleared");

        // Randomized mix of pixels, syncs, stalls and clears.
        for (int n = 0; n < 160; n++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r <= 6) host_event(16'($urandom), 1, ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0));
            else if (r == 7) host_event(16'h0000, 0, 1, 0);
            else if (r == 8) host_event(16'h0000, 0, 0, 1);
            else if (r == 9) set_ready(~iWrReady);
            else if (r == 10) clear_errs();
            else host_event(16'h0000, 0, 1, 1);
            check_state("rand");
        end
        set_ready(1);
        wait_drain();

        // Reset mid-frame with writes queued.
        set_ready(0);
        for (int i = 0; i < 3; i++) host_event(16'(16'h7700 + i), 1, 0, 0);
        @(posedge iCLOCKA); #3;
        iRESET = 1'b0;
        #1;
        chk("midrst_valid", oWrValid, 0);
        chk("midrst_ovf", oOverflow, 0);
        chk("midrst_clip", oClip, 0);
        expq.delete();
        mh = 0; mv = 0; mpage = 1'b0; movf = 1'b0; mclip = 1'b0; occ = 0;
        repeat (2) @(posedge iCLOCKA);
        #1;
        iRESET = 1'b1;
        iWrReady = 1'b1;
        repeat (2) @(posedge iCLOCKA);
        #1;
        check_state("after_rst");
        host_event(16'h4321, 1, 0, 0);
        wait_drain();
        chk("final_valid", oWrValid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
